mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences one instruction through FETCH, DECODE, EXEC, MEM and WB over 2–5+ cycles, sharing a single memory port between instruction fetch and data access. It is driven by the 6-bit opcode of the instruction register and uses the team's opcode map and `{1'b1,opcode}` ALU-op convention. It drives the PC, IR, register-file, ALU-mux and memory-port controls.

## Interface
Parameters: none. The opcode map is fixed.

Ports, in the form name, direction, width, meaning:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `opcode` input 6: `IR[31:26]`, valid from DECODE onward.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: write (store) request.
- `mem_size` output 2: access size; 1 = byte, 2 = half, 3 = word, 0 = idle.
- `iord` output 1: memory address source; 0 = PC, 1 = ALU result register.
- `ir_write` output 1: load IR.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU branch condition is true.
- `pc_src` output 2: PC source; 0 = ALU (PC+4), 1 = branch target register, 2 = jump target.
- `alu_src_a` output 1: ALU A input; 0 = PC, 1 = rs.
- `alu_src_b` output 2: ALU B input; 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- `alu_op` output 7: ALU operation code.
- `reg_write` output 1: register-file write enable.
- `reg_dst` output 2: destination register; 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg` output 2: write-back data; 0 = ALU, 1 = memory data, 2 = PC.
- `retire` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` output 1: sticky flag, unsupported opcode trapped.
- `state` output 3: current state, for debug.

## Operation
Opcode classes:
- R = 0.
- BR = 1, 4, 5.
- J = 2, 3 (3 is jal).
- IMM = 8, 10, 12, 13.
- LD = 32, 33, 35.
- ST = 40, 41, 43.
- All other opcodes are illegal.

`op_q` is a 6-bit register loaded from `opcode` in DECODE. EXEC, MEM and WB decode from `op_q`, never from the live `opcode` input.

State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Every output not listed for a state is 0.

- **FETCH**
  - Outputs: `mem_req`=1, `iord`=0, `mem_size`=3, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0.
  - When `mem_ready`=1: also `ir_write`=1, `pc_write`=1, `pc_src`=0, and go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**
  - Outputs: `alu_src_a`=0, `alu_src_b`=3, so the branch target is computed into the target register.
  - Illegal opcode: go to TRAP.
  - J: `pc_write`=1, `pc_src`=2, `retire`=1, go to FETCH. For opcode 3, also `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2.
  - Otherwise: go to EXEC.
- **EXEC**
  - `alu_op` = 0 for R, otherwise `{1'b1,op_q}`.
  - `alu_src_a`=1.
  - `alu_src_b`=0 for R/BR, 2 for IMM/LD/ST.
  - BR: `pc_write_cond`=1, `pc_src`=1, `retire`=1, go to FETCH.
  - LD/ST: go to MEM. R/IMM: go to WB.
- **MEM**
  - Outputs: `mem_req`=1, `iord`=1, `mem_we` = (ST).
  - `mem_size`: 32/40 give 1, 33/41 give 2, 35/43 give 3.
  - Wait in MEM while `mem_ready`=0.
  - On `mem_ready`: ST asserts `retire`=1 and goes to FETCH; LD goes to WB.
- **WB**
  - Outputs: `reg_write`=1; `reg_dst`=1 for R, else 0; `mem_to_reg`=1 for LD, else 0; `retire`=1.
  - Go to FETCH.
- **TRAP**
  - `illegal`=1; all other outputs 0.
  - Stays in TRAP until reset.

## Timing
- **Outputs:** combinational from `state`, `op_q`, `opcode` (DECODE only) and `mem_ready`. The state register updates on the rising edge of `clk`.
- **Reset:** when `reset_n`=0 is sampled at an edge, `state` becomes FETCH, `op_q` becomes 0 and `illegal` becomes 0. While `reset_n`=0, all outputs are forced to 0, including `mem_req`. The first `mem_req` appears in the first cycle with `reset_n`=1.
- **Memory handshake:** the request completes in the cycle where `mem_req` and `mem_ready` are both 1. Controls stay stable while waiting. A `mem_ready` seen outside FETCH/MEM is ignored.
- **Latency, with zero-wait memory:**
  - J: 2 cycles.
  - BR: 3 cycles.
  - R, IMM, ST: 4 cycles.
  - LD: 5 cycles.
  - Each wait cycle in FETCH or MEM adds 1.
- **Retire:** `retire` is asserted exactly once per completed instruction and never in TRAP.
- **Reset mid-operation:** reset during any state, including a MEM wait, aborts the instruction. No `retire` is issued and there is no write: `reg_write`, `mem_we` and `pc_write` are 0 during the reset cycle.

## Test plan
- **R-type (opcode 0), `mem_ready` tied 1:**
  - State sequence 0,1,2,4,0.
  - EXEC: `alu_op`=0, `alu_src_b`=0.
  - WB: `reg_write`=1, `reg_dst`=1, `retire`=1.
  - `retire` occurs once per 4 cycles.
- **lw (35), `mem_ready` low for 2 cycles in MEM:**
  - MEM held 3 cycles with `mem_req`=1, `iord`=1, `mem_size`=3, `mem_we`=0.
  - WB: `mem_to_reg`=1, `reg_dst`=0.
  - Total 7 cycles.
- **sb (40):**
  - EXEC: `alu_op`=7'b1101000, `alu_src_b`=2.
  - MEM: `mem_we`=1, `mem_size`=1, `retire`=1.
  - Returns to FETCH with no WB.
- **beq (4) then jal (3):**
  - beq: `pc_write_cond`=1, `pc_src`=1, `alu_op`=7'b1000100 in EXEC, 3 cycles.
  - jal: `pc_write`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2 in DECODE, 2 cycles.
- **Opcode 6 (illegal):**
  - DECODE goes to TRAP; `illegal`=1 and `mem_req`=0 for 10+ cycles with no `retire`.
  - Asserting `reset_n`=0 clears `illegal` and returns to FETCH.
- **Reset during a MEM wait of sw (43):**
  - All outputs are 0 that cycle.
  - Next cycle is FETCH with `mem_req`=1, `iord`=0.
  - No `mem_we` pulse and no `retire` for the aborted instruction.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port and drives PC, IR, register-file, ALU-mux and memory controls.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic [1:0] mem_size,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [6:0] alu_op,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       retire,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t     state_q, state_n;
   logic [5:0] op_q;
   logic       illegal_q;

   function automatic logic is_r(input logic [5:0] op);
      return op == 6'd0;
   endfunction
   function automatic logic is_br(input logic [5:0] op);
      return (op == 6'd1) || (op == 6'd4) || (op == 6'd5);
   endfunction
   function automatic logic is_j(input logic [5:0] op);
      return (op == 6'd2) || (op == 6'd3);
   endfunction
   function automatic logic is_imm(input logic [5:0] op);
      return (op == 6'd8) || (op == 6'd10) || (op == 6'd12) || (op == 6'd13);
   endfunction
   function automatic logic is_ld(input logic [5:0] op);
      return (op == 6'd32) || (op == 6'd33) || (op == 6'd35);
   endfunction
   function automatic logic is_st(input logic [5:0] op);
      return (op == 6'd40) || (op == 6'd41) || (op == 6'd43);
   endfunction
   function automatic logic is_legal(input logic [5:0] op);
      return is_r(op) || is_br(op) || is_j(op) || is_imm(op) || is_ld(op) || is_st(op);
   endfunction

   // op_q captures the opcode in DECODE so later states ignore the live IR bits
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         op_q      <= 6'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_n;
         if (state_q == S_DECODE) op_q <= opcode;
         if (state_n == S_TRAP) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_n = S_DECODE;
         S_DECODE: begin
            if (!is_legal(opcode))  state_n = S_TRAP;
            else if (is_j(opcode))  state_n = S_FETCH;
            else                    state_n = S_EXEC;
         end
         S_EXEC: begin
            if (is_br(op_q))                     state_n = S_FETCH;
            else if (is_ld(op_q) || is_st(op_q)) state_n = S_MEM;
            else                                 state_n = S_WB;
         end
         S_MEM:    if (mem_ready) state_n = is_st(op_q) ? S_FETCH : S_WB;
         S_WB:     state_n = S_FETCH;
         S_TRAP:   state_n = S_TRAP;
         default:  state_n = S_FETCH;
      endcase
   end

   // All outputs are forced low while reset is held so an aborted instruction
   // never writes the PC, register file or memory.
   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_size      = 2'd0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 7'd0;
      reg_write     = 1'b0;
      reg_dst       = 2'd0;
      mem_to_reg    = 2'd0;
      retire        = 1'b0;
      illegal       = 1'b0;
      state         = 3'd0;
      if (reset_n) begin
         state = state_q;
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               mem_size  = 2'd3;
               alu_src_b = 2'd1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            S_DECODE: begin
               alu_src_b = 2'd3;
               if (is_j(opcode)) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd2;
                  retire   = 1'b1;
                  if (opcode == 6'd3) begin
                     reg_write  = 1'b1;
                     reg_dst    = 2'd2;
                     mem_to_reg = 2'd2;
                  end
               end
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = is_r(op_q) ? 7'd0 : {1'b1, op_q};
               alu_src_b = (is_r(op_q) || is_br(op_q)) ? 2'd0 : 2'd2;
               if (is_br(op_q)) begin
                  pc_write_cond = 1'b1;
                  pc_src        = 2'd1;
                  retire        = 1'b1;
               end
            end
            S_MEM: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_we  = is_st(op_q);
               case (op_q[1:0])
                  2'b00:   mem_size = 2'd1;
                  2'b01:   mem_size = 2'd2;
                  default: mem_size = 2'd3;
               endcase
               if (mem_ready && is_st(op_q)) retire = 1'b1;
            end
            S_WB: begin
               reg_write  = 1'b1;
               reg_dst    = is_r(op_q) ? 2'd1 : 2'd0;
               mem_to_reg = is_ld(op_q) ? 2'd1 : 2'd0;
               retire     = 1'b1;
            end
            S_TRAP:  illegal = illegal_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: the driver pushes the expected output
// vector for every cycle it drives; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req;
      logic       mem_we;
      logic [1:0] mem_size;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [6:0] alu_op;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       retire;
      logic       illegal;
   } outs_t;
   localparam int W = $bits(outs_t);

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       mem_ready;
   outs_t      got;

   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           checks = 0;
   int           failures = 0;

   localparam logic [5:0] JUNK = 6'd6;

   mips_multicycle_ctrl dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (got.mem_req),
      .mem_we        (got.mem_we),
      .mem_size      (got.mem_size),
      .iord          (got.iord),
      .ir_write      (got.ir_write),
      .pc_write      (got.pc_write),
      .pc_write_cond (got.pc_write_cond),
      .pc_src        (got.pc_src),
      .alu_src_a     (got.alu_src_a),
      .alu_src_b     (got.alu_src_b),
      .alu_op        (got.alu_op),
      .reg_write     (got.reg_write),
      .reg_dst       (got.reg_dst),
      .mem_to_reg    (got.mem_to_reg),
      .retire        (got.retire),
      .illegal       (got.illegal),
      .state         (got.st)
   );

   // clock
   always #5 clk = ~clk;

   // expected-vector builders
   function automatic outs_t f_fetch(input logic rdy);
      outs_t e = '0;
      e.mem_req = 1'b1; e.mem_size = 2'd3; e.alu_src_b = 2'd1;
      if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      return e;
   endfunction
   function automatic outs_t f_decode();
      outs_t e = '0;
      e.st = 3'd1; e.alu_src_b = 2'd3;
      return e;
   endfunction
   function automatic outs_t f_jump(input logic link);
      outs_t e = '0;
      e.st = 3'd1; e.alu_src_b = 2'd3; e.pc_write = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1;
      if (link) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
      return e;
   endfunction
   function automatic outs_t f_exec(input logic [6:0] aop, input logic [1:0] b);
      outs_t e = '0;
      e.st = 3'd2; e.alu_src_a = 1'b1; e.alu_src_b = b; e.alu_op = aop;
      return e;
   endfunction
   function automatic outs_t f_branch(input logic [6:0] aop);
      outs_t e = '0;
      e.st = 3'd2; e.alu_src_a = 1'b1; e.alu_op = aop;
      e.pc_write_cond = 1'b1; e.pc_src = 2'd1; e.retire = 1'b1;
      return e;
   endfunction
   function automatic outs_t f_mem(input logic we, input logic [1:0] sz, input logic ret);
      outs_t e = '0;
      e.st = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = we; e.mem_size = sz; e.retire = ret;
      return e;
   endfunction
   function automatic outs_t f_wb(input logic [1:0] dst, input logic [1:0] m2r);
      outs_t e = '0;
      e.st = 3'd4; e.reg_write = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r; e.retire = 1'b1;
      return e;
   endfunction
   function automatic outs_t f_trap();
      outs_t e = '0;
      e.st = 3'd5; e.illegal = 1'b1;
      return e;
   endfunction

   // driver: inputs for one cycle plus the outputs expected during it
   task automatic step(input logic rn, input logic rdy, input logic [5:0] op,
                       input outs_t e, input string tag);
      reset_n   = rn;
      mem_ready = rdy;
      opcode    = op;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         string        t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", t, got, e);
         end
      end
   end

   initial begin
      reset_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
      @(posedge clk); #1;
      step(1'b0, 1'b0, 6'd0, '0, "reset0");
      step(1'b0, 1'b1, 6'd0, '0, "reset1");

      // two back-to-back R-types, memory always ready
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 6'd0, f_fetch(1'b1),              "r_fetch");
         step(1'b1, 1'b1, 6'd0, f_decode(),                 "r_decode");
         step(1'b1, 1'b1, JUNK, f_exec(7'd0, 2'd0),         "r_exec");
         step(1'b1, 1'b1, JUNK, f_wb(2'd1, 2'd0),           "r_wb");
      end

      // lw with two MEM wait cycles
      step(1'b1, 1'b1, 6'd35, f_fetch(1'b1),                "lw_fetch");
      step(1'b1, 1'b0, 6'd35, f_decode(),                   "lw_decode");
      step(1'b1, 1'b0, JUNK,  f_exec(7'b1100011, 2'd2),     "lw_exec");
      step(1'b1, 1'b0, JUNK,  f_mem(1'b0, 2'd3, 1'b0),      "lw_mem_wait0");
      step(1'b1, 1'b0, JUNK,  f_mem(1'b0, 2'd3, 1'b0),      "lw_mem_wait1");
      step(1'b1, 1'b1, JUNK,  f_mem(1'b0, 2'd3, 1'b0),      "lw_mem_done");
      step(1'b1, 1'b1, JUNK,  f_wb(2'd0, 2'd1),             "lw_wb");

      // sb preceded by a FETCH wait cycle
      step(1'b1, 1'b0, 6'd40, f_fetch(1'b0),                "sb_fetch_wait");
      step(1'b1, 1'b1, 6'd40, f_fetch(1'b1),                "sb_fetch");
      step(1'b1, 1'b1, 6'd40, f_decode(),                   "sb_decode");
      step(1'b1, 1'b1, JUNK,  f_exec(7'b1101000, 2'd2),     "sb_exec");
      step(1'b1, 1'b1, JUNK,  f_mem(1'b1, 2'd1, 1'b1),      "sb_mem");

      // sh and lh sizes
      step(1'b1, 1'b1, 6'd41, f_fetch(1'b1),                "sh_fetch");
      step(1'b1, 1'b1, 6'd41, f_decode(),                   "sh_decode");
      step(1'b1, 1'b1, JUNK,  f_exec(7'b1101001, 2'd2),     "sh_exec");
      step(1'b1, 1'b1, JUNK,  f_mem(1'b1, 2'd2, 1'b1),      "sh_mem");
      step(1'b1, 1'b1, 6'd33, f_fetch(1'b1),                "lh_fetch");
      step(1'b1, 1'b1, 6'd33, f_decode(),                   "lh_decode");
      step(1'b1, 1'b1, JUNK,  f_exec(7'b1100001, 2'd2),     "lh_exec");
      step(1'b1, 1'b1, JUNK,  f_mem(1'b0, 2'd2, 1'b0),      "lh_mem");
      step(1'b1, 1'b1, JUNK,  f_wb(2'd0, 2'd1),             "lh_wb");

      // addi
      step(1'b1, 1'b1, 6'd8,  f_fetch(1'b1),                "addi_fetch");
      step(1'b1, 1'b1, 6'd8,  f_decode(),                   "addi_decode");
      step(1'b1, 1'b1, JUNK,  f_exec(7'b1001000, 2'd2),     "addi_exec");
      step(1'b1, 1'b1, JUNK,  f_wb(2'd0, 2'd0),             "addi_wb");

      // beq, jal, j
      step(1'b1, 1'b1, 6'd4,  f_fetch(1'b1),                "beq_fetch");
      step(1'b1, 1'b1, 6'd4,  f_decode(),                   "beq_decode");
      step(1'b1, 1'b1, JUNK,  f_branch(7'b1000100),         "beq_exec");
      step(1'b1, 1'b1, 6'd3,  f_fetch(1'b1),                "jal_fetch");
      step(1'b1, 1'b1, 6'd3,  f_jump(1'b1),                 "jal_decode");
      step(1'b1, 1'b1, 6'd2,  f_fetch(1'b1),                "j_fetch");
      step(1'b1, 1'b1, 6'd2,  f_jump(1'b0),                 "j_decode");

      // illegal opcode traps until reset
      step(1'b1, 1'b1, 6'd6,  f_fetch(1'b1),                "ill_fetch");
      step(1'b1, 1'b1, 6'd6,  f_decode(),                   "ill_decode");
      for (int i = 0; i < 11; i++)
         step(1'b1, 1'(i % 2), 6'd0, f_trap(),              "ill_trap");
      step(1'b0, 1'b1, 6'd0,  '0,                           "ill_reset");

      // sw aborted by reset during a MEM wait
      step(1'b1, 1'b1, 6'd43, f_fetch(1'b1),                "sw_fetch");
      step(1'b1, 1'b1, 6'd43, f_decode(),                   "sw_decode");
      step(1'b1, 1'b0, JUNK,  f_exec(7'b1101011, 2'd2),     "sw_exec");
      step(1'b1, 1'b0, JUNK,  f_mem(1'b1, 2'd3, 1'b0),      "sw_mem_wait");
      step(1'b0, 1'b0, JUNK,  '0,                           "sw_reset");
      step(1'b1, 1'b1, 6'd0,  f_fetch(1'b1),                "post_reset_fetch");
      step(1'b1, 1'b1, 6'd0,  f_decode(),                   "post_reset_decode");

      // drain with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
